// File: rtl/fetch_queue.sv
// Four-entry (DEPTH) bundle FIFO between fetch and decode with single-cycle flush.
// Storage is an array of per-entry register slices; the head entry is read combinationally.

module fq_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset)  q <= '0;
    else if (we) q <= d;
endmodule

module fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_LEN = 32,
  parameter int INSN_LEN = 32,
  parameter int BHR_LEN  = 10,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_valid,
  input  logic [ADDR_LEN-1:0] if_pc,
  input  logic [ADDR_LEN-1:0] if_npc,
  input  logic [INSN_LEN-1:0] if_inst1,
  input  logic [INSN_LEN-1:0] if_inst2,
  input  logic                if_invalid2,
  input  logic                if_predict_cond,
  input  logic [BHR_LEN-1:0]  if_bhr,
  output logic                if_ready,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [ADDR_LEN-1:0] id_pc,
  output logic [ADDR_LEN-1:0] id_npc,
  output logic [INSN_LEN-1:0] id_inst1,
  output logic [INSN_LEN-1:0] id_inst2,
  output logic                id_invalid2,
  output logic                id_predict_cond,
  output logic [BHR_LEN-1:0]  id_bhr,
  input  logic                prmiss,
  output logic [CNT_W-1:0]    count
);

  typedef struct packed {
    logic [ADDR_LEN-1:0] pc;
    logic [ADDR_LEN-1:0] npc;
    logic [INSN_LEN-1:0] inst1;
    logic [INSN_LEN-1:0] inst2;
    logic                invalid2;
    logic                predict_cond;
    logic [BHR_LEN-1:0]  bhr;
  } bundle_t;

  localparam int BW = $bits(bundle_t);

  logic [PTR_W-1:0]          wp, rp;
  logic [CNT_W-1:0]          cnt;
  logic                      push, pop;
  bundle_t                   wr_b, head;
  logic [DEPTH-1:0][BW-1:0]  ent_q;

  // Handshake flags depend on registered occupancy only, never on the peer's strobe.
  assign if_ready = (cnt != CNT_W'(DEPTH));
  assign id_valid = (cnt != '0);
  assign push     = if_valid && if_ready && !prmiss;
  assign pop      = id_valid && id_ready && !prmiss;
  assign count    = cnt;

  assign wr_b = '{pc: if_pc, npc: if_npc, inst1: if_inst1, inst2: if_inst2,
                  invalid2: if_invalid2, predict_cond: if_predict_cond, bhr: if_bhr};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    fq_entry #(.W(BW)) u_ent (
      .clk   (clk),
      .reset (reset),
      .we    (push && (wp == PTR_W'(i))),
      .d     (wr_b),
      .q     (ent_q[i])
    );
  end

  // Flush clears only the bookkeeping; stale entries are unreachable once count is 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (prmiss) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head            = bundle_t'(ent_q[rp]);
  assign id_pc           = head.pc;
  assign id_npc          = head.npc;
  assign id_inst1        = head.inst1;
  assign id_inst2        = head.inst2;
  assign id_invalid2     = head.invalid2;
  assign id_predict_cond = head.predict_cond;
  assign id_bhr          = head.bhr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed + randomized bench for fetch_queue against a queue-based reference model.

module tb_fetch_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        inv2;
    logic        pcond;
    logic [9:0]  bhr;
  } bnd_t;

  logic        clk = 0;
  logic        reset = 0;
  logic        if_valid = 0, id_ready = 0, prmiss = 0;
  bnd_t        in_b = '0;
  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_npc, id_inst1, id_inst2;
  logic        id_invalid2, id_predict_cond;
  logic [9:0]  id_bhr;
  logic [2:0]  count;

  int n_chk = 0;
  int n_fail = 0;
  bnd_t model_q[$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_LEN(32), .INSN_LEN(32), .BHR_LEN(10)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(in_b.pc), .if_npc(in_b.npc),
    .if_inst1(in_b.i1), .if_inst2(in_b.i2), .if_invalid2(in_b.inv2),
    .if_predict_cond(in_b.pcond), .if_bhr(in_b.bhr), .if_ready(if_ready),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_npc(id_npc), .id_inst1(id_inst1), .id_inst2(id_inst2),
    .id_invalid2(id_invalid2), .id_predict_cond(id_predict_cond), .id_bhr(id_bhr),
    .prmiss(prmiss), .count(count)
  );

  function automatic bnd_t dut_head();
    return '{pc: id_pc, npc: id_npc, i1: id_inst1, i2: id_inst2,
             inv2: id_invalid2, pcond: id_predict_cond, bhr: id_bhr};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("count", 160'(count), 160'(model_q.size()));
    chk("if_ready", 160'(if_ready), 160'(model_q.size() < DEPTH));
    chk("id_valid", 160'(id_valid), 160'(model_q.size() != 0));
    if (model_q.size() != 0) chk("head", 160'(dut_head()), 160'(model_q[0]));
  endtask

  // Drive one cycle's inputs (called away from the edge), advance the model, then check.
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                      input logic pm, input logic inv2);
    bit push, pop;
    if_valid = v; id_ready = rdy; prmiss = pm;
    in_b = '{pc: pc, npc: pc + 32'd8, i1: $urandom, i2: $urandom, inv2: inv2,
             pcond: 1'($urandom), bhr: 10'($urandom)};
    push = v && (model_q.size() < DEPTH) && !pm;
    pop  = rdy && (model_q.size() != 0) && !pm;
    if (pm) model_q.delete();
    else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(in_b);
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_count", 160'(count), 160'(0));
    chk("rst_if_ready", 160'(if_ready), 160'(1));
    chk("rst_id_valid", 160'(id_valid), 160'(0));
    chk("rst_head", 160'(dut_head()), 160'(0));
    @(negedge clk);
    reset = 1;

    // fill
    for (int i = 0; i < 4; i++) begin
      step(1, 32'(i * 8), 0, 0, 0);
      chk("fill_count", 160'(count), 160'(i + 1));
    end
    chk("full_if_ready", 160'(if_ready), 160'(0));
    step(1, 32'h20, 0, 0, 0);
    chk("full_refuse_count", 160'(count), 160'(4));

    // in-order drain
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 160'(id_pc), 160'(i * 8));
      step(0, 32'h0, 1, 0, 0);
    end
    chk("drain_empty", 160'(id_valid), 160'(0));

    // streaming with wrap
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h100 + 32'(i * 8), 1, 0, (i == 3));
      chk("stream_count", 160'(count), 160'(1));
      chk("stream_pc", 160'(id_pc), 160'(32'h100 + 32'(i * 8)));
      chk("stream_inv2", 160'(id_invalid2), 160'(i == 3));
    end
    step(0, 32'h0, 1, 0, 0);

    // flush with concurrent push and pop
    for (int i = 0; i < 3; i++) step(1, 32'h180 + 32'(i * 8), 0, 0, 0);
    step(1, 32'h200, 1, 1, 0);
    chk("flush_count", 160'(count), 160'(0));
    chk("flush_id_valid", 160'(id_valid), 160'(0));
    chk("flush_if_ready", 160'(if_ready), 160'(1));
    step(1, 32'h300, 0, 0, 0);
    chk("post_flush_head", 160'(id_pc), 160'(32'h300));
    chk("post_flush_count", 160'(count), 160'(1));

    // full with simultaneous pop
    for (int i = 0; i < 3; i++) step(1, 32'h400 + 32'(i * 8), 0, 0, 0);
    chk("full2_count", 160'(count), 160'(4));
    step(1, 32'h500, 1, 0, 0);
    chk("full_pop_count", 160'(count), 160'(3));
    chk("full_pop_ready", 160'(if_ready), 160'(1));
    chk("full_pop_head", 160'(id_pc), 160'(32'h400));

    // async reset mid-stream
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 0, 0, 0);
    chk("pre_rst_count", 160'(count), 160'(2));
    #2 reset = 0;
    #1;
    chk("arst_id_valid", 160'(id_valid), 160'(0));
    chk("arst_count", 160'(count), 160'(0));
    chk("arst_id_pc", 160'(id_pc), 160'(0));
    model_q.delete();
    @(negedge clk);
    reset = 1;

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
